ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-ported RAM between the instruction-fetch requester (IF stage) and the
//  data requester (MEM stage) of the pipelined datapath. One transaction is outstanding at a
//  time; data has priority. Completion is signalled to the datapath by dropping iwait/dwait.
// PARAMETERS
//  ADDR_W        32  address width (byte address)
//  DATA_W        32  word width
//  STARVE_LIMIT  4   consecutive data grants tolerated while a fetch waits (ARB_FAIR_EN only)
// PORTS
//  CLK       in   1       clock; all state updates on rising edge
//  nRST      in   1       reset, synchronous, active-low
//  iREN      in   1       instruction read request; held until iwait==0
//  iaddr     in   ADDR_W  instruction address; stable while iREN
//  iload     out  DATA_W  instruction word; valid in the cycle iwait==0
//  iwait     out  1       1 = fetch not complete
//  dREN      in   1       data read request; held until dwait==0
//  dWEN      in   1       data write request; dREN&dWEN illegal (treated as write)
//  daddr     in   ADDR_W  data address
//  dstore    in   DATA_W  write data
//  dload     out  DATA_W  read data; valid in the cycle dwait==0
//  dwait     out  1       1 = data access not complete
//  ramREN    out  1       RAM read enable
//  ramWEN    out  1       RAM write enable
//  ramaddr   out  ADDR_W  RAM address
//  ramstore  out  DATA_W  RAM write data
//  ramload   in   DATA_W  RAM read data
//  ramstate  in   2       ramstate_t: FREE, BUSY, ACCESS, ERROR
//  memerr    out  1       1-cycle pulse: the completing access ended in ERROR
// BEHAVIOUR
//  - FSM arb_state_t {ARB_IDLE, ARB_IXFER, ARB_DXFER}; reset -> ARB_IDLE.
//  - IDLE: (dREN|dWEN) -> DXFER; else iREN -> IXFER; else stay. Both pending -> DXFER.
//  - IXFER: ramREN=1, ramaddr=iaddr. DXFER: ramREN=dREN&!dWEN, ramWEN=dWEN,
//    ramaddr=daddr, ramstore=dstore. IDLE: ramREN=ramWEN=0, ramaddr=ramstore=0.
//  - Completion: in XFER, ramstate==ACCESS or ERROR -> owner's wait=0 that cycle (combinational),
//    iload/dload=ramload passthrough, memerr=(ramstate==ERROR); next state IDLE.
//  - FREE/BUSY in XFER: hold state and RAM drive. No timeout.
//  - Minimum latency: request cycle N -> grant edge N -> completion earliest cycle N+1; one IDLE
//    turnaround cycle between back-to-back transactions.
//  - iwait=1 / dwait=1 whenever not completing own transaction, including IDLE and reset.
//  - Withdrawal: owner drops its request in XFER -> abort, enables deasserted that cycle,
//    next state IDLE, no completion, no memerr.
//  - Reset mid-transaction: at the nRST=0 edge, state -> IDLE, enables 0 next cycle; RAM
//    completion seen while in reset is discarded.
//  - Reset values: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, memerr=0, loads=ramload.
// CONFIGURATION
//  ARB_FAIR_EN defined: 3-bit dstreak counter; +1 on each DXFER grant taken while iREN=1,
//   cleared on IXFER grant or when iREN=0 at IDLE; saturates. In IDLE with both pending and
//   dstreak==STARVE_LIMIT -> IXFER. Reset clears dstreak.
//  ARB_FAIR_EN undefined: strict data priority, no counter; fetch may starve.
// STRUCTURE
//  - cpu_types_pkg: add arb_state_t enum and ARB_STARVE_W localparam; reuse ramstate_t.
//  - One sub-module: arb_grant_sel (combinational next-owner choice from requests + dstreak);
//    FSM, RAM drive muxes and completion decode stay in ram_arbiter.
// TESTING
//  1 iREN=1 iaddr=0x40, RAM BUSY 2 cycles then ACCESS ramload=0x8C010004 -> ramREN=1,
//    ramaddr=0x40 for 3 cycles; iwait=0, iload=0x8C010004 on cycle 3; IDLE next.
//  2 iREN and dWEN daddr=0x100 dstore=0xDEAD same cycle -> DXFER first (ramWEN=1), then
//    after completion + IDLE turnaround, IXFER; dwait falls before iwait.
//  3 dREN in DXFER, ramstate=ERROR -> dwait=0 and memerr=1 for exactly one cycle; IDLE next.
//  4 nRST=0 during IXFER with ramstate=ACCESS -> iwait stays 1, next cycle ramREN=0, IDLE.
//  5 ARB_FAIR_EN, STARVE_LIMIT=4, iREN held, dREN re-asserted every idle -> 4 data grants,
//    5th grant IXFER, dstreak=0; without macro all grants data.
//  6 dREN dropped mid-DXFER -> ramREN=0 same cycle, no dwait=0 pulse, state IDLE.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared datapath types: RAM handshake states and arbiter FSM states.
// Fairness width is sized here so the counter and selector agree.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IXFER,
        ARB_DXFER
    } arb_state_t;

    localparam int ARB_STARVE_W = 3;

endpackage

// File: rtl/arb_grant_sel.sv
// Next-owner choice for the RAM arbiter: data first unless the fetch
// side has been passed over STARVE_LIMIT times in a row (FAIR_EN only).
module arb_grant_sel
    import cpu_types_pkg::*;
#(
    parameter bit FAIR_EN      = 1'b0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    ireq,
    input  logic                    dreq,
    input  logic [ARB_STARVE_W-1:0] dstreak,
    output logic [1:0]              grant
);

    localparam logic [ARB_STARVE_W-1:0] LIMIT = ARB_STARVE_W'(STARVE_LIMIT);

    logic starved;

    assign starved = FAIR_EN && (dstreak >= LIMIT);

    always_comb begin
        grant = ARB_IDLE;
        if (dreq && !(ireq && starved)) begin
            grant = ARB_DXFER;
        end else if (ireq) begin
            grant = ARB_IXFER;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-ported RAM arbiter between IF (fetch) and MEM (data) requesters.
// Define ARB_FAIR_EN to bound fetch starvation with a data-grant streak counter.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              memerr
);

`ifdef ARB_FAIR_EN
    localparam bit FAIR_EN = 1'b1;
`else
    localparam bit FAIR_EN = 1'b0;
`endif

    arb_state_t              state;
    arb_state_t              grant;
    logic [1:0]              grant_raw;
    ramstate_t               rs;
    logic                    dreq;
    logic                    own_req;
    logic                    done;
    logic [ARB_STARVE_W-1:0] dstreak;

    assign rs    = ramstate_t'(ramstate);
    assign dreq  = dREN | dWEN;
    assign grant = arb_state_t'(grant_raw);

    arb_grant_sel #(
        .FAIR_EN      (FAIR_EN),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_sel (
        .ireq    (iREN),
        .dreq    (dreq),
        .dstreak (dstreak),
        .grant   (grant_raw)
    );

    always_comb begin
        own_req = 1'b0;
        unique case (state)
            ARB_IXFER: own_req = iREN;
            ARB_DXFER: own_req = dreq;
            default:   own_req = 1'b0;
        endcase
    end

    // A completion arriving while nRST is low is dropped on the floor.
    assign done   = nRST && own_req && (rs == ACCESS || rs == ERROR);
    assign iwait  = !(done && state == ARB_IXFER);
    assign dwait  = !(done && state == ARB_DXFER);
    assign memerr = done && (rs == ERROR);
    assign iload  = ramload;
    assign dload  = ramload;

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        unique case (state)
            ARB_IXFER: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            ARB_DXFER: begin
                ramREN   = dREN & !dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= ARB_IDLE;
        end else begin
            unique case (state)
                ARB_IDLE: state <= grant;
                ARB_IXFER,
                ARB_DXFER: begin
                    if (!own_req || done) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef ARB_FAIR_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            dstreak <= '0;
        end else if (state == ARB_IDLE) begin
            if (!iREN || grant == ARB_IXFER) begin
                dstreak <= '0;
            end else if (grant == ARB_DXFER && dstreak != '1) begin
                dstreak <= dstreak + ARB_STARVE_W'(1);
            end
        end
    end
`else
    assign dstreak = '0;
`endif

endmodule
